// File: rtl/vec_pkg.sv
// Shared types for the scalar/vector memory-port arbiter.
package vec_pkg;

    // Which requester a memory access (and its read response) belongs to.
    typedef enum logic {
        OWN_SCALAR = 1'b0,
        OWN_VECTOR = 1'b1
    } mem_owner_e;

    // Arbiter state: free arbitration or locked to a vector burst.
    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_VBURST = 1'b1
    } arb_state_e;

    // Tag carried alongside each access while its read data is outstanding.
    typedef struct packed {
        logic       valid;
        mem_owner_e owner;
    } rsp_tag_t;

    localparam rsp_tag_t RSP_TAG_NONE = '{valid: 1'b0, owner: OWN_SCALAR};

endpackage

// File: rtl/vec_rsp_tracker.sv
// Fixed-latency delay line of response tags; the head lines up with mem_rdata.
module vec_rsp_tracker
    import vec_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic     clk,
    input  logic     n_rst,
    input  rsp_tag_t i_push,
    output rsp_tag_t o_head,
    output logic     o_any_valid
);

    rsp_tag_t r_pipe [MEM_LAT];

    // Advance every tag one stage per cycle; a tag is pushed every cycle (valid=0 when idle).
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < MEM_LAT; i++) begin
                r_pipe[i] <= RSP_TAG_NONE;
            end
        end else begin
            r_pipe[0] <= i_push;
            for (int i = 1; i < MEM_LAT; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign o_head = r_pipe[MEM_LAT-1];

    // Report whether any read is still travelling through the delay line.
    always_comb begin
        o_any_valid = 1'b0;
        for (int i = 0; i < MEM_LAT; i++) begin
            o_any_valid = o_any_valid | r_pipe[i].valid;
        end
    end

endmodule

// File: rtl/vec_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between scalar accesses and
// locked multi-beat vector bursts, with owner-routed fixed-latency read data.
module vec_mem_arbiter
    import vec_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int SEW       = 32,
    parameter int MEM_LAT   = 1,
    parameter int MAX_BURST = 16
) (
    input  logic            clk,
    input  logic            n_rst,
    input  logic            sc_req,
    input  logic            sc_we,
    input  logic [XLEN-1:0] sc_addr,
    input  logic [XLEN-1:0] sc_wdata,
    output logic            sc_gnt,
    output logic            sc_rvalid,
    input  logic            vec_req,
    input  logic            vec_we,
    input  logic [XLEN-1:0] vec_addr,
    input  logic [SEW-1:0]  vec_wdata,
    input  logic            vec_last,
    output logic            vec_gnt,
    output logic            vec_rvalid,
    output logic [SEW-1:0]  rdata,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [SEW-1:0]  mem_wdata,
    input  logic [SEW-1:0]  mem_rdata,
    output logic            busy,
    output logic            burst_err
);

    localparam int             CNT_W   = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

    if (SEW != XLEN) begin : g_sew_check
        $error("vec_mem_arbiter: SEW must equal XLEN");
    end
    if (MEM_LAT < 1) begin : g_lat_check
        $error("vec_mem_arbiter: MEM_LAT must be at least 1");
    end
    if (MAX_BURST < 2) begin : g_burst_check
        $error("vec_mem_arbiter: MAX_BURST must be at least 2");
    end

    arb_state_e       r_state;
    mem_owner_e       r_rr_ptr;
    logic [CNT_W-1:0] r_beat_cnt;
    logic             r_burst_err;

    logic             w_sc_gnt;
    logic             w_vec_gnt;
    logic [CNT_W-1:0] w_cnt_inc;
    rsp_tag_t         w_push;
    rsp_tag_t         w_head;
    logic             w_inflight;

    assign w_cnt_inc = r_beat_cnt + ONE_CNT;

    // Grant decision: round-robin on contention while idle, vector only while locked.
    always_comb begin
        w_sc_gnt  = 1'b0;
        w_vec_gnt = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                if (sc_req && vec_req) begin
                    if (r_rr_ptr == OWN_SCALAR) begin
                        w_sc_gnt = 1'b1;
                    end else begin
                        w_vec_gnt = 1'b1;
                    end
                end else begin
                    w_sc_gnt  = sc_req;
                    w_vec_gnt = vec_req;
                end
            end
            ARB_VBURST: begin
                w_vec_gnt = vec_req;
            end
            default: begin
                w_sc_gnt  = 1'b0;
                w_vec_gnt = 1'b0;
            end
        endcase
    end

    // Arbitration FSM: burst lock, round-robin pointer, beat counter and sticky overrun flag.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state     <= ARB_IDLE;
            r_rr_ptr    <= OWN_SCALAR;
            r_beat_cnt  <= '0;
            r_burst_err <= 1'b0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (sc_req && vec_req) begin
                        r_rr_ptr <= w_vec_gnt ? OWN_SCALAR : OWN_VECTOR;
                    end
                    if (w_vec_gnt && !vec_last) begin
                        r_state    <= ARB_VBURST;
                        r_beat_cnt <= ONE_CNT;
                    end
                end
                ARB_VBURST: begin
                    if (w_vec_gnt) begin
                        if (vec_last) begin
                            r_state    <= ARB_IDLE;
                            r_rr_ptr   <= OWN_SCALAR;
                            r_beat_cnt <= '0;
                        end else if (w_cnt_inc == MAX_CNT) begin
                            // Runaway burst: flag it and release the port.
                            r_burst_err <= 1'b1;
                            r_state     <= ARB_IDLE;
                            r_rr_ptr    <= OWN_SCALAR;
                            r_beat_cnt  <= '0;
                        end else begin
                            r_beat_cnt <= w_cnt_inc;
                        end
                    end
                end
                default: begin
                    r_state    <= ARB_IDLE;
                    r_rr_ptr   <= OWN_SCALAR;
                    r_beat_cnt <= '0;
                end
            endcase
        end
    end

    // Memory port mux driven from whichever requester holds the grant.
    always_comb begin
        mem_req   = w_sc_gnt | w_vec_gnt;
        mem_we    = 1'b0;
        mem_addr  = {XLEN{1'b0}};
        mem_wdata = {SEW{1'b0}};
        if (w_vec_gnt) begin
            mem_we    = vec_we;
            mem_addr  = vec_addr;
            mem_wdata = vec_wdata;
        end else if (w_sc_gnt) begin
            mem_we    = sc_we;
            mem_addr  = sc_addr;
            mem_wdata = sc_wdata;
        end else begin
            mem_we    = 1'b0;
            mem_addr  = {XLEN{1'b0}};
            mem_wdata = {SEW{1'b0}};
        end
    end

    // Tag for this cycle's access: only reads expect data back.
    always_comb begin
        w_push.valid = mem_req & ~mem_we;
        w_push.owner = w_vec_gnt ? OWN_VECTOR : OWN_SCALAR;
    end

    vec_rsp_tracker #(
        .MEM_LAT (MEM_LAT)
    ) u_rsp_tracker (
        .clk         (clk),
        .n_rst       (n_rst),
        .i_push      (w_push),
        .o_head      (w_head),
        .o_any_valid (w_inflight)
    );

    assign sc_gnt     = w_sc_gnt;
    assign vec_gnt    = w_vec_gnt;
    assign sc_rvalid  = w_head.valid & (w_head.owner == OWN_SCALAR);
    assign vec_rvalid = w_head.valid & (w_head.owner == OWN_VECTOR);
    assign rdata      = w_head.valid ? mem_rdata : {SEW{1'b0}};
    assign busy       = (r_state == ARB_VBURST) | w_inflight;
    assign burst_err  = r_burst_err;

endmodule
